// File: rtl/cpu_operand_stage.sv
// RV32I operand stage: register file with write bypass, decode of the ALU/branch
// subset, and a single output slot that forwards writebacks into held operands.
module cpu_operand_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_instr_i,
  input  logic [31:0] in_pc_i,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] src_a_o,
  output logic [31:0] src_b_o,
  output logic [31:0] src_imm_o,
  output logic        use_imm_o,
  output logic [2:0]  alu_op_o,
  output logic        compare_unsigned_o,
  output logic        is_branch_o,
  output logic [2:0]  branch_cond_o,
  output logic [4:0]  rd_o,
  output logic        illegal_o
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned RIDX_W = 5;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F3_W   = 3;

  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  // rs1/rs2 hold the register index that supplied src_a/src_b, 0 when none did
  typedef struct packed {
    logic [XLEN-1:0]   src_a;
    logic [XLEN-1:0]   src_b;
    logic [XLEN-1:0]   src_imm;
    logic              use_imm;
    logic [F3_W-1:0]   alu_op;
    logic              compare_unsigned;
    logic              is_branch;
    logic [F3_W-1:0]   branch_cond;
    logic [RIDX_W-1:0] rd;
    logic              illegal;
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
  } slot_t;

  logic [NREG-1:1][XLEN-1:0] rf_q, rf_d;
  slot_t                     slot_q, slot_d;
  logic                      valid_q, valid_d;

  slot_t             dec;
  logic              accept;
  logic [OPC_W-1:0]  opcode;
  logic [F3_W-1:0]   funct3;
  logic [6:0]        funct7;
  logic [RIDX_W-1:0] rd_idx, rs1_idx, rs2_idx;
  logic [XLEN-1:0]   imm_i, imm_b, imm_u;
  logic [XLEN-1:0]   rs1_val, rs2_val;
  logic              alu_f3_ok;

  assign in_ready_o = !valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  assign opcode  = in_instr_i[6:0];
  assign rd_idx  = in_instr_i[11:7];
  assign funct3  = in_instr_i[14:12];
  assign rs1_idx = in_instr_i[19:15];
  assign rs2_idx = in_instr_i[24:20];
  assign funct7  = in_instr_i[31:25];

  assign imm_i = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
  assign imm_b = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                  in_instr_i[30:25], in_instr_i[11:8], 1'b0};
  assign imm_u = {in_instr_i[31:12], 12'b0};

  // Shifts are not supported by the downstream ALU
  assign alu_f3_ok = (funct3 != 3'b001) && (funct3 != 3'b101);

  // Register reads with same-cycle writeback bypass; x0 reads zero
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_idx != '0) begin
      if (wb_en_i && (wb_rd_i == rs1_idx)) rs1_val = wb_data_i;
      else                                 rs1_val = rf_q[rs1_idx];
    end
    if (rs2_idx != '0) begin
      if (wb_en_i && (wb_rd_i == rs2_idx)) rs2_val = wb_data_i;
      else                                 rs2_val = rf_q[rs2_idx];
    end
  end

  // Decode; anything not matched below leaves the all-zero illegal payload
  always_comb begin
    dec         = '0;
    dec.illegal = 1'b1;
    case (opcode)
      OPC_OP_IMM: begin
        if (alu_f3_ok) begin
          dec.illegal          = 1'b0;
          dec.src_a            = rs1_val;
          dec.rs1              = rs1_idx;
          dec.src_imm          = imm_i;
          dec.use_imm          = 1'b1;
          dec.alu_op           = funct3;
          dec.compare_unsigned = (funct3 == 3'b011);
          dec.rd               = rd_idx;
        end
      end
      OPC_OP: begin
        if (alu_f3_ok && (funct7 == '0)) begin
          dec.illegal          = 1'b0;
          dec.src_a            = rs1_val;
          dec.rs1              = rs1_idx;
          dec.src_b            = rs2_val;
          dec.rs2              = rs2_idx;
          dec.alu_op           = funct3;
          dec.compare_unsigned = (funct3 == 3'b011);
          dec.rd               = rd_idx;
        end
      end
      OPC_LUI: begin
        dec.illegal = 1'b0;
        dec.src_imm = imm_u;
        dec.use_imm = 1'b1;
        dec.rd      = rd_idx;
      end
      OPC_AUIPC: begin
        dec.illegal = 1'b0;
        dec.src_a   = in_pc_i;
        dec.src_imm = imm_u;
        dec.use_imm = 1'b1;
        dec.rd      = rd_idx;
      end
      OPC_BRANCH: begin
        if (funct3[2:1] != 2'b01) begin
          dec.illegal          = 1'b0;
          dec.src_a            = rs1_val;
          dec.rs1              = rs1_idx;
          dec.src_b            = rs2_val;
          dec.rs2              = rs2_idx;
          dec.src_imm          = imm_b;
          dec.is_branch        = 1'b1;
          dec.branch_cond      = funct3;
          dec.compare_unsigned = funct3[1];
        end
      end
      default: ;
    endcase
  end

  // Next state: register file write, slot load/drain, forwarding into a held slot
  always_comb begin
    rf_d    = rf_q;
    slot_d  = slot_q;
    valid_d = valid_q;
    if (wb_en_i && (wb_rd_i != '0)) rf_d[wb_rd_i] = wb_data_i;
    if (accept) begin
      slot_d  = dec;
      valid_d = 1'b1;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end else if (valid_q && wb_en_i && (wb_rd_i != '0)) begin
      if (slot_q.rs1 == wb_rd_i) slot_d.src_a = wb_data_i;
      if (slot_q.rs2 == wb_rd_i) slot_d.src_b = wb_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rf_q    <= '0;
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      rf_q    <= rf_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid_o        = valid_q;
  assign src_a_o            = slot_q.src_a;
  assign src_b_o            = slot_q.src_b;
  assign src_imm_o          = slot_q.src_imm;
  assign use_imm_o          = slot_q.use_imm;
  assign alu_op_o           = slot_q.alu_op;
  assign compare_unsigned_o = slot_q.compare_unsigned;
  assign is_branch_o        = slot_q.is_branch;
  assign branch_cond_o      = slot_q.branch_cond;
  assign rd_o               = slot_q.rd;
  assign illegal_o          = slot_q.illegal;

endmodule
